// File: rtl/barrel_shift_right_pipe.sv
// Pipelined right barrel shifter: logical, arithmetic and rotate modes.
// Stage i shifts by 2**i when amt bit i is set; valid/ready on both sides.
module barrel_shift_right_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [SHW-1:0]   stg_valid;
  logic [WIDTH-1:0] stg_data [SHW];
  logic [SHW-1:0]   stg_amt  [SHW];
  logic [1:0]       stg_mode [SHW];

  logic [SHW-1:0]   stg_load;
  logic [SHW-1:0]   src_valid;
  logic [WIDTH-1:0] src_data [SHW];
  logic [SHW-1:0]   src_amt  [SHW];
  logic [1:0]       src_mode [SHW];
  logic [WIDTH-1:0] nxt_data [SHW];

  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] mode,
                                                   input logic en,
                                                   input int k);
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (mode)
        2'b01:   r = $signed(d) >>> k;
        2'b10:   r = (d >> k) | (d << (WIDTH - k));
        default: r = d >> k;
      endcase
    end
    return r;
  endfunction

  // A stage can take a new word if it is empty or its occupant moves on;
  // this ripples from out_ready back to in_ready without touching in_valid.
  always_comb begin
    stg_load = '0;
    stg_load[SHW-1] = !stg_valid[SHW-1] || out_ready;
    for (int i = SHW - 2; i >= 0; i--) begin
      stg_load[i] = !stg_valid[i] || stg_load[i+1];
    end
  end

  assign in_ready = stg_load[0] && !rst;

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_mode[0]  = in_mode;
    for (int i = 1; i < SHW; i++) begin
      src_valid[i] = stg_valid[i-1];
      src_data[i]  = stg_data[i-1];
      src_amt[i]   = stg_amt[i-1];
      src_mode[i]  = stg_mode[i-1];
    end
    for (int i = 0; i < SHW; i++) begin
      nxt_data[i] = shift_stage(src_data[i], src_mode[i], src_amt[i][i], 1 << i);
    end
  end

  // Payload only updates when a real word arrives; bubbles just clear valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= '0;
      for (int i = 0; i < SHW; i++) begin
        stg_data[i] <= '0;
        stg_amt[i]  <= '0;
        stg_mode[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SHW; i++) begin
        if (stg_load[i]) begin
          stg_valid[i] <= src_valid[i];
          if (src_valid[i]) begin
            stg_data[i] <= nxt_data[i];
            stg_amt[i]  <= src_amt[i];
            stg_mode[i] <= src_mode[i];
          end
        end
      end
    end
  end

  assign out_valid = stg_valid[SHW-1];
  assign out_data  = stg_data[SHW-1];

endmodule

// File: doc/barrel_shift_right_pipe.md
Name: barrel_shift_right_pipe

Overview:
- 8-bit right barrel shifter, the complement of the team's combinational left shifter.
- Supports logical, arithmetic and rotate-right modes.
- Built as a 3-stage registered pipeline (shift by 1, then 2, then 4) with valid/ready handshakes on both sides.
- Sits between a producer and a consumer on the datapath and supports full-throughput streaming and backpressure.

Parameters:
- WIDTH, 8, data width in bits.
- SHW, 3, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data/in_amt/in_mode.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  right-shift amount, 0..WIDTH-1.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Transfer rules: an input transfer occurs on a clock edge where in_valid && in_ready. An output transfer occurs on a clock edge where out_valid && out_ready.
- Stage registers: each of S1, S2, S3 holds valid, data, remaining amt bits, and mode.
  - S1 captures the input shifted by 1 if in_amt[0].
  - S2 captures S1 shifted by 2 if amt[1].
  - S3 captures S2 shifted by 4 if amt[2].
  - out_data and out_valid are driven directly from S3's registers.
- Per-stage shift by k:
  - Logical: zero fill into the top k bits.
  - Arithmetic: replicate the stage input MSB into the top k bits.
  - Rotate: the low k bits move into the top k bits.
  - Mode 11 behaves exactly like 00.
- Advance rules:
  - S3 may load when S3 is empty or out_ready=1.
  - S2 may load when S2 is empty or S3 may load.
  - S1 may load when S1 is empty or S2 may load.
  - in_ready is S1-may-load. It is combinational from out_ready through the stage valids, with no combinational path from in_valid.
  - A stage that loads with no valid upstream word clears its valid bit.
- Latency: an accepted word appears on out_data with out_valid=1 exactly 3 clock edges after acceptance, given no stall.
- Throughput: one word per cycle while out_ready=1.
- Stall: while out_ready=0 and out_valid=1, out_data is held stable. Upstream stages fill one per cycle until all three are full, then in_ready=0.
  - No word is dropped or duplicated; order is preserved.
- Simultaneous events: with the pipeline full and out_ready=1 and in_valid=1 in the same cycle, one word leaves and one word enters, and in_ready=1.
- Boundaries:
  - amt=0 passes data unchanged in all modes.
  - amt=WIDTH-1 logical leaves only the original MSB in bit 0.
  - amt=WIDTH-1 arithmetic yields all copies of the sign bit.
- Reset:
  - All stage valids are 0 and all stage data/amt/mode registers are 0.
  - out_valid=0 and out_data=0.
  - in_ready=1 combinationally once rst deasserts.
  - While rst=1, in_ready is 0.
  - Reset asserted mid-stream discards all in-flight words, and nothing appears on the output afterwards.
- Parameterization: WIDTH/SHW generalize to SHW stages of shift 2^i. All required behaviour is defined for the default 8/3.

Test Plan:
- Mode checks: in_data=8'hB6, in_amt=3, with out_ready=1.
  - mode 00 -> out_data=8'h16 three cycles later.
  - mode 01 -> 8'hF6.
  - mode 10 -> 8'hD6.
  - mode 11 -> 8'h16.
- Exhaustive sweep: all 256 data × 8 amt × 4 modes streamed back-to-back with out_ready=1 -> every result matches a reference model, in order, one per cycle after 3-cycle fill. Also amt=0 returns the input and 8'h80 arithmetic amt=7 -> 8'hFF.
- Backpressure: stream 5 words (8'h01..8'h05, amt 0) with out_ready=0 -> in_ready drops after 3 words are accepted and out_data holds 8'h01 stable. Release out_ready -> outputs are 01,02,03,04,05 with no loss or duplication.
- Random out_ready toggling (50%) during 1000 random inputs -> scoreboard order and values match, and out_data never changes while out_valid=1 && out_ready=0.
- Reset mid-stream: assert rst for 1 cycle with 3 words in flight -> out_valid=0 and out_data=0 the next cycle, no stale word appears afterwards, and in_ready=1 after rst falls.
- Full-pipeline simultaneous accept/emit: with S1–S3 full, out_ready=1 and in_valid=1 -> in_ready=1 and exactly one transfer occurs on each side that cycle.
